// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS main controller: sequencing FSM, op/funct decode, ALU control
//
// Purpose: registered-state Moore FSM that steps each instruction through
// fetch/decode/execute/memory/writeback, and drives every datapath enable and
// mux select, including the 4-bit ALU operation word.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (state -> FETCH, write strobes off)
//   op, funct  instruction[31:26] and instruction[5:0] from the instruction register
//   zero       ALU zero flag (only used for the branch PC enable)
//   mem_ready  memory completes the current access (sampled in FETCH/MEMRD/MEMWR)
//   iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
//   alusrcb[1:0], pcsrc[1:0], alucontrol[3:0], pcen   datapath controls
//   retire     pulse in the final cycle of every instruction
//   illegal    pulse in DECODE for an unsupported op/funct
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       pcen,
  output logic       retire,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_BGTZEX  = 4'd9;
  localparam logic [3:0] S_IMMEX   = 4'd10;
  localparam logic [3:0] S_IMMWB   = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LI    = 6'b011000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SRLV = 6'b000110;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1111;
  localparam logic [3:0] ALU_XORI = 4'b0100;
  localparam logic [3:0] ALU_LUI  = 4'b0101;
  localparam logic [3:0] ALU_SRLV = 4'b0110;
  localparam logic [3:0] ALU_BGTZ = 4'b0011;
  localparam logic [3:0] ALU_LI   = 4'b0111;

  logic [3:0] r_state;
  logic [3:0] w_next;

  logic       w_funct_ok;
  logic [3:0] w_rtype_alu;
  logic [3:0] w_imm_alu;

  // Raw (pre-reset-gating) strobes; the ports below mask them with reset.
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_retire;
  logic       w_illegal;

  always_comb begin
    w_funct_ok  = 1'b1;
    w_rtype_alu = ALU_ADD;
    case (funct)
      FN_ADD:  w_rtype_alu = ALU_ADD;
      FN_SUB:  w_rtype_alu = ALU_SUB;
      FN_AND:  w_rtype_alu = ALU_AND;
      FN_OR:   w_rtype_alu = ALU_OR;
      FN_SLT:  w_rtype_alu = ALU_SLT;
      FN_SRLV: w_rtype_alu = ALU_SRLV;
      default: w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_imm_alu = ALU_ADD;
    case (op)
      OP_XORI: w_imm_alu = ALU_XORI;
      OP_LUI:  w_imm_alu = ALU_LUI;
      OP_LI:   w_imm_alu = ALU_LI;
      default: w_imm_alu = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    iord       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE: begin
            if (w_funct_ok) begin
              w_next = S_RTYPEEX;
            end else begin
              w_illegal = 1'b1;
              w_retire  = 1'b1;
            end
          end
          OP_LW, OP_SW:                     w_next = S_MEMADR;
          OP_BEQ:                           w_next = S_BEQEX;
          OP_BGTZ:                          w_next = S_BGTZEX;
          OP_ADDI, OP_XORI, OP_LUI, OP_LI:  w_next = S_IMMEX;
          OP_J:                             w_next = S_JEX;
          default: begin
            w_illegal = 1'b1;
            w_retire  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW) begin
          w_next = S_MEMRD;
        end else if (op == OP_SW) begin
          w_next = S_MEMWR;
        end
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = mem_ready;
        w_next     = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = w_rtype_alu;
        w_next     = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        w_branch   = 1'b1;
        pcsrc      = 2'b01;
        w_retire   = 1'b1;
      end
      S_BGTZEX: begin
        // The ALU's BGTZ op yields 0 when rs > 0, so "taken" is zero=1.
        alusrca    = 1'b1;
        alucontrol = ALU_BGTZ;
        w_branch   = 1'b1;
        pcsrc      = 2'b01;
        w_retire   = 1'b1;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = w_imm_alu;
        w_next     = S_IMMWB;
      end
      S_IMMWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_retire  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // State is already FETCH while reset is low; these gates also suppress the
  // FETCH strobes that would otherwise follow mem_ready during reset.
  assign irwrite  = reset & w_irwrite;
  assign memwrite = reset & w_memwrite;
  assign regwrite = reset & w_regwrite;
  assign retire   = reset & w_retire;
  assign illegal  = reset & w_illegal;
  assign pcen     = reset & (w_pcwrite | (w_branch & zero));

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main controller for the extended MIPS datapath. It holds the instruction-sequencing state machine, decodes `op`/`funct`, and drives every datapath enable and mux select. It also produces the 4-bit `alucontrol` word consumed by the ALU, so it is the producing end of the ALU control interface. It sits between the instruction register and the datapath. It handshakes with the unified instruction/data memory through `mem_ready`.

## Interface
- No parameters; all encodings are fixed below.
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `op` in 6: instruction[31:26] from the instruction register
- `funct` in 6: instruction[5:0]
- `zero` in 1: ALU zero flag
- `mem_ready` in 1: memory completes the current access this cycle
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut
- `memwrite` out 1: memory write strobe
- `irwrite` out 1: instruction register load
- `regwrite` out 1: register file write
- `regdst` out 1: write register select, 1 = rd, 0 = rt
- `memtoreg` out 1: write data select, 1 = memory data, 0 = ALUOut
- `alusrca` out 1: ALU a select, 0 = PC, 1 = rs
- `alusrcb` out 2: ALU b select, 00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2
- `pcsrc` out 2: PC source, 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alucontrol` out 4: ALU operation
- `pcen` out 1: PC load, equal to pcwrite | (branch & zero)
- `retire` out 1: one-cycle pulse in the final cycle of each instruction
- `illegal` out 1: one-cycle pulse from DECODE on an unsupported op or funct

## Operation
- **ALU codes:** AND 0000, OR 0001, ADD 0010, SUB 1010, SLT 1111, XORI 0100, LUI 0101, SRLV 0110, BGTZ 0011, LI 0111.
- **Opcodes:** R-type 000000, lw 100011, sw 101011, beq 000100, bgtz 000111, addi 001000, xori 001110, lui 001111, li 011000, j 000010.
- **R-type funct:** add 100000, sub 100010, and 100100, or 100101, slt 101010, srlv 000110. Any other funct is illegal.
- **Moore FSM, registered state.** All outputs decode combinationally from state, plus `mem_ready` and `zero` where noted. Outputs not listed for a state are 0, and `alucontrol` defaults to 0010.
- **States and transitions:**
  - FETCH: iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00. irwrite and pcwrite both equal `mem_ready`. Go to DECODE when `mem_ready`, else stay.
  - DECODE: alusrca=0, alusrcb=11, ADD (branch target into ALUOut).
    - lw/sw go to MEMADR.
    - R-type with legal funct goes to RTYPEEX.
    - beq goes to BEQEX; bgtz goes to BGTZEX.
    - addi/xori/lui/li go to IMMEX; j goes to JEX.
    - Anything else: pulse `illegal` and `retire`, then go to FETCH.
  - MEMADR: alusrca=1, alusrcb=10, ADD. lw goes to MEMRD, sw goes to MEMWR.
  - MEMRD: iord=1. Go to MEMWB when `mem_ready`.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1, retire. Go to FETCH.
  - MEMWR: iord=1, memwrite=1, retire=`mem_ready`. Go to FETCH when `mem_ready`. `memwrite` stays asserted while waiting.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol per funct. Go to RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1, retire. Go to FETCH.
  - BEQEX: alusrca=1, alusrcb=00, SUB, branch=1, pcsrc=01, retire. Go to FETCH.
  - BGTZEX: alusrca=1, BGTZ, branch=1, pcsrc=01, retire. Go to FETCH. The ALU returns 0 when rs > 0, so the branch is taken on `zero`=1.
  - IMMEX: alusrca=1, alusrcb=10. alucontrol is ADD for addi, XORI for xori, LUI for lui, LI for li. Go to IMMWB.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1, retire. Go to FETCH.
  - JEX: pcsrc=10, pcwrite=1, retire. Go to FETCH.
- **Reset:** `reset` low forces state to FETCH asynchronously. While `reset` is low, irwrite, pcwrite, pcen, memwrite, regwrite, retire and illegal are forced to 0. All other outputs take their FETCH values: alusrcb=01, alucontrol=0010, all else 0.
- **Reset mid-instruction:** the instruction is abandoned with no further writes. Fetch restarts on the first edge after `reset` rises.

## Timing
- Cycle counts with no memory wait:
  - 5 cycles: lw.
  - 4 cycles: sw, R-type, and the immediate ops (addi, xori, lui, li).
  - 3 cycles: beq, bgtz, j.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No output changes while waiting.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- `op` and `funct` are sampled only in DECODE and later. They must be stable from the cycle after the irwrite edge until `retire`.
- `pcen` is combinational from `zero` in BEQEX and BGTZEX. No other output depends on `zero`.
- `retire` fires exactly once per instruction, including illegal ones.

## Test plan
- **Reset during MEMWR.** Drive `reset`=0 with `mem_ready`=0 -> state is FETCH immediately, `memwrite`=0 and `alucontrol`=0010 while `reset` is low, and FETCH restarts after release.
- **lw with two wait cycles.** FETCH `mem_ready`=1, then MEMRD `mem_ready`=0,0,1 -> 7 cycles total, `regwrite`=1 and `memtoreg`=1 only in the last cycle, one `retire`.
- **R-type sweep.** Run each legal funct -> RTYPEEX `alucontrol` is 0010/1010/0000/0001/1111/0110 respectively. funct 000111 -> `illegal` pulse in DECODE and no `regwrite`.
- **Branches.** bgtz with `zero`=1 -> `pcen`=1, `pcsrc`=01. bgtz with `zero`=0 -> `pcen`=0. beq with `zero`=1 -> `pcen`=1 and `alucontrol`=1010.
- **Immediate ops.** xori/lui/li -> IMMEX `alucontrol`=0100/0101/0111, `alusrcb`=10, then IMMWB `regwrite`=1 with `regdst`=0, 4 cycles each.
- **j then sw back-to-back.** j -> `pcsrc`=10 and `pcwrite`=1 in cycle 3. sw (`mem_ready`=1) -> `memwrite`=1 and `iord`=1 in cycle 4. Exactly 2 `retire` pulses.
